// File: rtl/vga_box_scheduler.sv
// Once-per-frame box motion controller: detects entry into vertical blanking,
// steps the box with edge bounce, and commits new corners only during blanking.
module vga_box_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 200,
  parameter int BOX_H    = 200,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] counter_y,
  input  logic [3:0] sw,
  output logic [9:0] box_x0,
  output logic [9:0] box_y0,
  output logic [9:0] box_x1,
  output logic [9:0] box_y1,
  output logic [7:0] frame_count,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [9:0] XMAX   = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0] YMAX   = 10'(V_ACTIVE - BOX_H);
  localparam logic [9:0] V_LINE = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t     state, state_nxt;
  logic [9:0] prev_y;
  logic [9:0] x, y;
  logic       dir_x, dir_y;
  logic [2:0] step;
  logic       pause_q;
  logic       tick;
  logic [2:0] step_now;
  logic [10:0] x_sum, y_sum;
  logic       sw_unused;

  assign sw_unused = sw[3];
  assign tick      = (counter_y == V_LINE) && (prev_y != V_LINE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // x uses the live switch value in CALC_X; y uses the copy latched there.
  always_comb begin
    step_now = {1'b0, sw[2:1]} + 3'd1;
    x_sum    = {1'b0, x} + {8'b0, step_now};
    y_sum    = {1'b0, y} + {8'b0, step};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = CALC_X;
      CALC_X:  state_nxt = CALC_Y;
      CALC_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_y      <= '0;
      x           <= 10'(X_INIT);
      y           <= 10'(Y_INIT);
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      step        <= 3'd1;
      pause_q     <= 1'b0;
      box_x0      <= 10'(X_INIT);
      box_y0      <= 10'(Y_INIT);
      box_x1      <= 10'(X_INIT + BOX_W - 1);
      box_y1      <= 10'(Y_INIT + BOX_H - 1);
      frame_count <= '0;
    end else begin
      prev_y <= counter_y;
      case (state)
        CALC_X: begin
          step    <= step_now;
          pause_q <= sw[0];
          if (!sw[0]) begin
            if (dir_x) begin
              if (x_sum >= {1'b0, XMAX}) begin
                x     <= XMAX;
                dir_x <= 1'b0;
              end else begin
                x <= x_sum[9:0];
              end
            end else if (x <= {7'b0, step_now}) begin
              x     <= '0;
              dir_x <= 1'b1;
            end else begin
              x <= x - {7'b0, step_now};
            end
          end
        end
        CALC_Y: begin
          if (!pause_q) begin
            if (dir_y) begin
              if (y_sum >= {1'b0, YMAX}) begin
                y     <= YMAX;
                dir_y <= 1'b0;
              end else begin
                y <= y_sum[9:0];
              end
            end else if (y <= {7'b0, step}) begin
              y     <= '0;
              dir_y <= 1'b1;
            end else begin
              y <= y - {7'b0, step};
            end
          end
        end
        COMMIT: begin
          box_x0      <= x;
          box_y0      <= y;
          box_x1      <= x + 10'(BOX_W - 1);
          box_y1      <= y + 10'(BOX_H - 1);
          frame_count <= frame_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
